// File: rtl/traffic_phase_sequencer.sv
// Traffic intersection phase sequencer: round-robin greens with demand skip,
// yellow/all-red clearance and emergency preemption; optional pedestrian walk via TPS_PED_EN.
module traffic_phase_sequencer #(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned GREEN_CYC  = 7,
    parameter int unsigned YELLOW_CYC = 2,
    parameter int unsigned ALLRED_CYC = 1,
    parameter int unsigned WALK_CYC   = 4,
    parameter int unsigned CNT_W      = 4,
    localparam int unsigned PH_W      = $clog2(NUM_PHASES),
    localparam int unsigned LIGHTS_W  = 3 * NUM_PHASES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PHASES-1:0] demand,
    input  logic                  preempt_req,
    input  logic [PH_W-1:0]       preempt_phase,
    input  logic                  ped_req,
    output logic [LIGHTS_W-1:0]   lights,
    output logic                  walk,
    output logic [CNT_W-1:0]      count,
    output logic [2:0]            ps,
    output logic [PH_W-1:0]       active_phase
);

    typedef enum logic [2:0] {
        S_ALLRED  = 3'd0,
        S_GREEN   = 3'd1,
        S_YELLOW  = 3'd2,
        S_WALK    = 3'd3,
        S_PREEMPT = 3'd4
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_t          state_q;
    state_t          state_d;
    logic [PH_W-1:0] phase_d;
    logic [PH_W-1:0] next_green;
    logic [CNT_W-1:0] count_d;
    logic            preempt_vld;
    logic            walk_ok;

    // Out-of-range preempt targets are treated as no request.
    assign preempt_vld = preempt_req && (32'(preempt_phase) < NUM_PHASES);

    // Lamp pattern for a given state and active approach.
    function automatic logic [LIGHTS_W-1:0] lights_for(input state_t s, input logic [PH_W-1:0] ph);
        logic [LIGHTS_W-1:0] l;
        l = '0;
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            l[3*i +: 3] = LAMP_RED;
            if (ph == PH_W'(i)) begin
                if (s == S_GREEN || s == S_PREEMPT) l[3*i +: 3] = LAMP_GREEN;
                else if (s == S_YELLOW)             l[3*i +: 3] = LAMP_YELLOW;
            end
        end
        return l;
    endfunction

    // Next green: first demanding approach after the current one, current checked last.
    always_comb begin
        logic found;
        int unsigned idx;
        found      = 1'b0;
        idx        = 0;
        next_green = PH_W'((32'(active_phase) + 32'd1) % NUM_PHASES);
        for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
            idx = (32'(active_phase) + k) % NUM_PHASES;
            if (!found && demand[PH_W'(idx)]) begin
                next_green = PH_W'(idx);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = active_phase;
        case (state_q)
            S_GREEN: begin
                if (preempt_vld) begin
                    state_d = (preempt_phase == active_phase) ? S_PREEMPT : S_YELLOW;
                end else if (count == CNT_W'(GREEN_CYC - 1)) begin
                    state_d = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (count == CNT_W'(YELLOW_CYC - 1)) state_d = S_ALLRED;
            end
            S_ALLRED: begin
                if (count == CNT_W'(ALLRED_CYC - 1)) begin
                    if (preempt_vld) begin
                        state_d = S_PREEMPT;
                        phase_d = preempt_phase;
                    end else if (walk_ok) begin
                        state_d = S_WALK;
                    end else begin
                        state_d = S_GREEN;
                        phase_d = next_green;
                    end
                end
            end
            S_WALK: begin
                if (count == CNT_W'(WALK_CYC - 1)) state_d = S_ALLRED;
            end
            S_PREEMPT: begin
                if (!preempt_vld) state_d = S_YELLOW;
            end
            default: state_d = S_ALLRED;
        endcase
    end

    // Counter restarts on any transition; PREEMPT can last indefinitely so it saturates there.
    always_comb begin
        if (state_d != state_q)                   count_d = '0;
        else if (state_q == S_PREEMPT && &count)  count_d = count;
        else                                      count_d = count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ALLRED;
            count        <= '0;
            active_phase <= PH_W'(NUM_PHASES - 1);
            lights       <= lights_for(S_ALLRED, '0);
            walk         <= 1'b0;
        end else begin
            state_q      <= state_d;
            count        <= count_d;
            active_phase <= phase_d;
            lights       <= lights_for(state_d, phase_d);
            walk         <= (state_d == S_WALK);
        end
    end

    assign ps = state_q;

`ifdef TPS_PED_EN
    logic ped_pend_q;
    logic from_walk_q;

    // A walk is only granted if the last clearance did not itself follow a walk.
    assign walk_ok = ped_pend_q && !from_walk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pend_q  <= 1'b0;
            from_walk_q <= 1'b0;
        end else begin
            ped_pend_q <= (ped_pend_q && !(state_d == S_WALK && state_q != S_WALK)) || ped_req;
            if (state_d == S_ALLRED && state_q != S_ALLRED) begin
                from_walk_q <= (state_q == S_WALK);
            end
        end
    end
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign walk_ok    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: directed scenarios plus random traffic against a
// cycle-level reference model built from the phase timing rules.
module tb_traffic_phase_sequencer;

    localparam int NP    = 4;
    localparam int G_CYC = 7;
    localparam int Y_CYC = 2;
    localparam int A_CYC = 1;
    localparam int W_CYC = 4;
    localparam int CW    = 4;
    localparam int PW    = 2;
    localparam int LW    = 3 * NP;
`ifdef TPS_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    localparam int K_AR = 0, K_G = 1, K_Y = 2, K_W = 3, K_P = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] demand = '0;
    logic          preempt_req = 1'b0;
    logic [PW-1:0] preempt_phase = '0;
    logic          ped_req = 1'b0;
    logic [LW-1:0] lights;
    logic          walk;
    logic [CW-1:0] count;
    logic [2:0]    ps;
    logic [PW-1:0] active_phase;

    traffic_phase_sequencer dut (
        .clk(clk), .rst(rst), .demand(demand), .preempt_req(preempt_req),
        .preempt_phase(preempt_phase), .ped_req(ped_req), .lights(lights),
        .walk(walk), .count(count), .ps(ps), .active_phase(active_phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: current interval kind, cycles spent in it, approach, ped memory.
    int m_kind, m_elapsed, m_ap, m_last_served;
    bit m_ped;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick_green(input int ap, input logic [NP-1:0] d);
        for (int k = 1; k <= NP; k++) begin
            int idx;
            idx = (ap + k) % NP;
            if (((d >> idx) & 1) != 0) return idx;
        end
        return (ap + 1) % NP;
    endfunction

    function automatic logic [LW-1:0] exp_lights(input int kind, input int ap);
        logic [LW-1:0] e;
        e = '0;
        for (int i = 0; i < NP; i++) begin
            int code;
            code = 4;
            if (i == ap && (kind == K_G || kind == K_P)) code = 1;
            if (i == ap && kind == K_Y) code = 2;
            e = e | (LW'(code) << (3 * i));
        end
        return e;
    endfunction

    task automatic model_step();
        int  nk, nap;
        bit  pv;
        pv = preempt_req && (int'(preempt_phase) < NP);
        if (rst) begin
            m_kind = K_AR; m_elapsed = 0; m_ap = NP - 1; m_ped = 1'b0; m_last_served = -1;
            return;
        end
        nk = m_kind; nap = m_ap;
        if (m_kind == K_G) begin
            if (pv) nk = (int'(preempt_phase) == m_ap) ? K_P : K_Y;
            else if (m_elapsed + 1 >= G_CYC) nk = K_Y;
        end else if (m_kind == K_Y) begin
            if (m_elapsed + 1 >= Y_CYC) nk = K_AR;
        end else if (m_kind == K_W) begin
            if (m_elapsed + 1 >= W_CYC) nk = K_AR;
        end else if (m_kind == K_P) begin
            if (!pv) nk = K_Y;
        end else if (m_elapsed + 1 >= A_CYC) begin
            if (pv) begin nk = K_P; nap = int'(preempt_phase); end
            else if (PED && m_ped && m_last_served != K_W) nk = K_W;
            else begin nk = K_G; nap = pick_green(m_ap, demand); end
        end
        if (PED) m_ped = (m_ped && !(nk == K_W && m_kind != K_W)) || ped_req;
        if (m_kind != K_AR) m_last_served = m_kind;
        if (nk != m_kind) m_elapsed = 0;
        else if (m_kind != K_P || m_elapsed < (1 << CW) - 1) m_elapsed++;
        m_kind = nk; m_ap = nap;
    endtask

    task automatic tick(input bit r, input logic [NP-1:0] d, input bit pr,
                        input logic [PW-1:0] pp, input bit pd);
        @(negedge clk);
        rst = r; demand = d; preempt_req = pr; preempt_phase = pp; ped_req = pd;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("ps", 32'(ps), 32'(m_kind));
        check("count", 32'(count), 32'(m_elapsed));
        check("phase", 32'(active_phase), 32'(m_ap));
        check("lights", 32'(lights), 32'(exp_lights(m_kind, m_ap)));
        check("walk", 32'(walk), 32'(m_kind == K_W));
    endtask

    initial begin
        logic [NP-1:0] rd;
        bit            rp, rpd;
        logic [PW-1:0] rpp;

        // Reset then free rotation with no demand.
        tick(1, '0, 0, '0, 0);
        check("rst_lights", 32'(lights), 32'h924);
        check("rst_phase", 32'(active_phase), 32'd3);
        tick(0, '0, 0, '0, 0);
        check("first_g0_ps", 32'(ps), 32'd1);
        check("first_g0_lights", 32'(lights), 32'h921);
        for (int i = 0; i < 40; i++) tick(0, '0, 0, '0, 0);
        check("rotation_back_g0", 32'(active_phase), 32'd0);

        // Constant demand on approach 2 only; then reset mid-yellow.
        tick(1, 4'b0100, 0, '0, 0);
        tick(0, 4'b0100, 0, '0, 0);
        check("d2_green", 32'(lights[8:6]), 32'b001);
        for (int i = 0; i < 8; i++) tick(0, 4'b0100, 0, '0, 0);
        check("d2_yellow_c1", 32'(lights[8:6]), 32'b010);
        tick(1, 4'b0100, 0, '0, 0);
        check("midrst_ps", 32'(ps), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_lights", 32'(lights), 32'h924);
        check("midrst_phase", 32'(active_phase), 32'd3);

        // Preempt to approach 3 during G0 count 2.
        tick(1, '0, 0, '0, 0);
        for (int i = 0; i < 3; i++) tick(0, '0, 0, '0, 0);
        tick(0, '0, 1, 2'd3, 0);
        check("pre_yellow0", 32'(ps), 32'd2);
        for (int i = 0; i < 25; i++) tick(0, '0, 1, 2'd3, 0);
        check("pre_hold_lights", 32'(lights[11:9]), 32'b001);
        check("pre_sat_count", 32'(count), 32'hf);
        for (int i = 0; i < 4; i++) tick(0, '0, 0, 2'd3, 0);

        // Pending ped and preempt together at all-red end.
        tick(1, '0, 0, '0, 0);
        tick(0, '0, 0, '0, 0);
        tick(0, '0, 0, '0, 1);
        for (int i = 0; i < 7; i++) tick(0, '0, (i > 4), 2'd2, 0);
        for (int i = 0; i < 5; i++) tick(0, '0, 1, 2'd2, 0);
        for (int i = 0; i < 12; i++) tick(0, '0, 0, 2'd2, 0);

        // Random traffic.
        rd = '0; rp = 0; rpp = '0;
        tick(1, '0, 0, '0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rd = NP'($urandom);
            if ($urandom_range(0, 39) == 0) begin rp = ~rp; rpp = PW'($urandom); end
            rpd = ($urandom_range(0, 29) == 0);
            tick(($urandom_range(0, 499) == 0), rd, rp, rpp, rpd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
TRAFFIC_PHASE_SEQUENCER -- requirements
Module: traffic_phase_sequencer

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4, number of vehicle approaches (2..8).
REQ-002 SHALL have parameter GREEN_CYC, default 7, green duration in clk cycles (>=1).
REQ-003 SHALL have parameter YELLOW_CYC, default 2, yellow duration in cycles (>=1).
REQ-004 SHALL have parameter ALLRED_CYC, default 1, all-red clearance duration in cycles (>=1).
REQ-005 SHALL have parameter WALK_CYC, default 4, pedestrian walk duration in cycles (>=1).
REQ-006 SHALL have parameter CNT_W, default 4, counter width; must hold max duration minus 1.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port demand, input, NUM_PHASES, per-approach vehicle-present level.
REQ-010 SHALL have port preempt_req, input, 1, emergency preemption level.
REQ-011 SHALL have port preempt_phase, input, PH_W=$clog2(NUM_PHASES), approach to preempt to.
REQ-012 SHALL have port ped_req, input, 1, pedestrian button pulse.
REQ-013 SHALL have port lights, output, 3*NUM_PHASES, approach i at bits [3i+2:3i], {red,yellow,green}.
REQ-014 SHALL have port walk, output, 1, pedestrian walk lamp.
REQ-015 SHALL have ports count (output, CNT_W, in-state cycle counter), ps (output, 3, state), active_phase (output, PH_W).

Function
REQ-016 SHALL encode ps: ALLRED=0, GREEN=1, YELLOW=2, WALK=3, PREEMPT=4; all outputs registered.
REQ-017 SHALL set count to 0 on every state change and increment it by 1 each cycle otherwise.
REQ-018 SHALL drive lights: active approach 3'b001 in GREEN/PREEMPT, 3'b010 in YELLOW; every other approach, and all approaches in ALLRED/WALK, 3'b100.
REQ-019 SHALL leave GREEN for YELLOW when count==GREEN_CYC-1, and YELLOW for ALLRED when count==YELLOW_CYC-1.
REQ-020 SHALL at ALLRED end (count==ALLRED_CYC-1) choose, by priority: PREEMPT on preempt_phase if preempt_req; else WALK if ped pending and previous state was not WALK; else GREEN.
REQ-021 SHALL select the GREEN approach as the first index after active_phase, wrapping, with demand bit set (active_phase itself is checked last); if demand==0, active_phase+1 modulo NUM_PHASES.
REQ-022 SHALL, when preempt_req rises during GREEN on an approach other than preempt_phase, go to YELLOW on the next edge irrespective of count.
REQ-023 SHALL, when preempt_req is high in GREEN on preempt_phase, enter PREEMPT on the next edge keeping the same green.
REQ-024 SHALL hold PREEMPT while preempt_req is high (count saturates at all-ones) and go to YELLOW on the edge after it falls.
REQ-025 SHALL ignore preempt_phase values >= NUM_PHASES (treated as preempt_req low).

Reset
REQ-026 SHALL on rst at a clock edge set ps=ALLRED, count=0, active_phase=NUM_PHASES-1, all lights 3'b100, walk=0, ped pending cleared; rst overrides all inputs and is honoured mid-state.

Configuration
REQ-027 SHALL, with macro TPS_PED_EN defined, latch ped_req into a pending flag, serve it via WALK (all red, walk=1, WALK_CYC cycles, then ALLRED), clear the flag on entering WALK, and re-latch ped_req during WALK.
REQ-028 SHALL, with TPS_PED_EN undefined, keep the same ports, ignore ped_req, tie walk=0, and never reach WALK.

Verification
REQ-029 SHALL cover: rst 1 cycle, demand=0 -> AR 1 cycle, G0 7, Y0 2, AR 1, G1 ...; 40-cycle rotation back to G0.
REQ-030 SHALL cover: demand=4'b0100 constant -> only approach 2 greens: G2 7, Y 2, AR 1, repeat; lights[8:6] cycle 001/010/100.
REQ-031 SHALL cover: preempt_req=1, preempt_phase=3 at G0 count 2 -> Y0 next edge, AR 1, PREEMPT lights[11:9]=001 until release, then Y3 2 cycles.
REQ-032 SHALL cover (TPS_PED_EN): ped_req pulse in G1 -> Y1, AR, WALK 4 cycles walk=1 all 100, AR, then G2.
REQ-033 SHALL cover: preempt_req and pending ped both at AR end -> PREEMPT wins; ped served after preemption releases.
REQ-034 SHALL cover: rst during Y2 count 1 -> next edge ps=0, count=0, all lights 100, active_phase=3.
